// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous memory.
// Each command takes an ISSUE cycle; reads add an RDWAIT cycle to catch the return data.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module mem_arbiter #(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_req,
  input  logic                  p0_wr_rd,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wr_data,
  input  logic                  p1_req,
  input  logic                  p1_wr_rd,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wr_data,
  output logic                  p0_gnt,
  output logic                  p0_rd_valid,
  output logic [DATA_WIDTH-1:0] p0_rd_data,
  output logic                  p1_gnt,
  output logic                  p1_rd_valid,
  output logic [DATA_WIDTH-1:0] p1_rd_data,
  output logic                  mem_en,
  output logic                  mem_wr_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;

  state_t                  state_q, state_d;
  logic                    last_q, last_d;
  logic                    win_q, win_d;
  logic [1:0]              gnt_q, gnt_d;
  logic [1:0]              rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0]   rd_data_q [2];
  logic [DATA_WIDTH-1:0]   rd_data_d [2];
  logic                    mem_en_q, mem_en_d;
  logic                    mem_wr_rd_q, mem_wr_rd_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;

  logic [1:0]              req;
  logic [1:0]              cmd_wr;
  logic [ADDR_WIDTH-1:0]   cmd_addr [2];
  logic [DATA_WIDTH-1:0]   cmd_wdata [2];
  logic                    sel;

  assign req          = {p1_req, p0_req};
  assign cmd_wr       = {p1_wr_rd, p0_wr_rd};
  assign cmd_addr[0]  = p0_addr;
  assign cmd_addr[1]  = p1_addr;
  assign cmd_wdata[0] = p0_wr_data;
  assign cmd_wdata[1] = p1_wr_data;

  // On a tie the port that was not granted last wins; otherwise the lone requester.
  assign sel = (req == 2'b11) ? ~last_q : req[1];

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    win_d       = win_q;
    gnt_d       = 2'b00;
    rd_valid_d  = 2'b00;
    rd_data_d   = rd_data_q;
    mem_en_d    = 1'b0;
    mem_wr_rd_d = mem_wr_rd_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          win_d       = sel;
          gnt_d[sel]  = 1'b1;
          mem_en_d    = 1'b1;
          mem_wr_rd_d = cmd_wr[sel];
          mem_addr_d  = cmd_addr[sel];
          mem_wdata_d = cmd_wdata[sel];
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        last_d  = win_q;
        state_d = mem_wr_rd_q ? IDLE : RDWAIT;
      end
      RDWAIT: begin
        rd_data_d[win_q]  = mem_rd_data;
        rd_valid_d[win_q] = 1'b1;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      win_q       <= 1'b0;
      gnt_q       <= 2'b00;
      rd_valid_q  <= 2'b00;
      rd_data_q   <= '{default: '0};
      mem_en_q    <= 1'b0;
      mem_wr_rd_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      win_q       <= win_d;
      gnt_q       <= gnt_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      mem_en_q    <= mem_en_d;
      mem_wr_rd_q <= mem_wr_rd_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign p0_gnt      = gnt_q[0];
  assign p1_gnt      = gnt_q[1];
  assign p0_rd_valid = rd_valid_q[0];
  assign p1_rd_valid = rd_valid_q[1];
  assign p0_rd_data  = rd_data_q[0];
  assign p1_rd_data  = rd_data_q[1];
  assign mem_en      = mem_en_q;
  assign mem_wr_rd   = mem_wr_rd_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wdata_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random two-port traffic, checked
// against a transaction-level model (accept windows, round-robin, reference memory).
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req;
  logic [1:0]    wr;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdata [2];
  logic          p0_gnt, p1_gnt, p0_rd_valid, p1_rd_valid;
  logic [DW-1:0] p0_rd_data, p1_rd_data;
  logic          mem_en, mem_wr_rd, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .p0_req(req[0]), .p0_wr_rd(wr[0]), .p0_addr(addr[0]), .p0_wr_data(wdata[0]),
    .p1_req(req[1]), .p1_wr_rd(wr[1]), .p1_addr(addr[1]), .p1_wr_data(wdata[1]),
    .p0_gnt(p0_gnt), .p0_rd_valid(p0_rd_valid), .p0_rd_data(p0_rd_data),
    .p1_gnt(p1_gnt), .p1_rd_valid(p1_rd_valid), .p1_rd_data(p1_rd_data),
    .mem_en(mem_en), .mem_wr_rd(mem_wr_rd), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .busy(busy)
  );

  // Environment memory: synchronous, read data one cycle after the enable edge.
  logic [DW-1:0] env_mem [1 << AW];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr_rd) env_mem[mem_addr] <= mem_wr_data;
      else           mem_rd_data <= env_mem[mem_addr];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model state, indexed by rising-edge count.
  int            e = 0;
  int            free_e = 0;
  int            rv_edge = -1;
  int            rv_port = 0;
  logic [DW-1:0] rv_data;
  int            last = 1;
  logic [DW-1:0] ref_mem [1 << AW];
  logic [1:0]    exp_gnt, exp_rv;
  logic          exp_en, exp_wr, exp_busy;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;
  logic [DW-1:0] exp_rd [2];

  logic [1:0]    pend = 2'b00;
  int            gq[$];
  int            rv0q[$];

  task automatic model_edge();
    int w;
    exp_gnt = 2'b00;
    exp_en  = 1'b0;
    exp_rv  = 2'b00;
    if (rst) begin
      free_e = e + 1;
      last = 1;
      rv_edge = -1;
      exp_wr = 1'b0;
      exp_addr = '0;
      exp_wdata = '0;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
    end else begin
      if (rv_edge == e) begin
        exp_rv[rv_port] = 1'b1;
        exp_rd[rv_port] = rv_data;
      end
      if (e >= free_e && req != 2'b00) begin
        if (req[0] && req[1]) w = (last == 0) ? 1 : 0;
        else                  w = req[1] ? 1 : 0;
        exp_gnt[w] = 1'b1;
        exp_en     = 1'b1;
        exp_wr     = wr[w];
        exp_addr   = addr[w];
        exp_wdata  = wdata[w];
        last = w;
        if (wr[w]) begin
          ref_mem[addr[w]] = wdata[w];
          free_e = e + 2;
        end else begin
          rv_edge = e + 2;
          rv_port = w;
          rv_data = ref_mem[addr[w]];
          free_e  = e + 3;
        end
      end
    end
    exp_busy = (e < free_e - 1);
  endtask

  // One clock: model at the edge, compare 1ns later, release granted ports at the negedge.
  task automatic cycle();
    logic [1:0] g;
    @(posedge clk);
    e++;
    model_edge();
    #1;
    chk("p0_gnt", p0_gnt, exp_gnt[0]);
    chk("p1_gnt", p1_gnt, exp_gnt[1]);
    chk("gnt_exclusive", p0_gnt & p1_gnt, 0);
    chk("mem_en", mem_en, exp_en);
    chk("mem_wr_rd", mem_wr_rd, exp_wr);
    chk("mem_addr", mem_addr, exp_addr);
    chk("mem_wr_data", mem_wr_data, exp_wdata);
    chk("p0_rd_valid", p0_rd_valid, exp_rv[0]);
    chk("p1_rd_valid", p1_rd_valid, exp_rv[1]);
    chk("p0_rd_data", p0_rd_data, exp_rd[0]);
    chk("p1_rd_data", p1_rd_data, exp_rd[1]);
    chk("busy", busy, exp_busy);
    g = {p1_gnt, p0_gnt};
    if (g[0]) gq.push_back(0);
    if (g[1]) gq.push_back(1);
    if (p0_rd_valid) rv0q.push_back(e);
    if (g != 2'b00)
      $display("edge %0d grant p%0d %s addr=%0h wdata=%0h", e, g[1] ? 1 : 0,
               mem_wr_rd ? "WR" : "RD", mem_addr, mem_wr_data);
    @(negedge clk);
    for (int p = 0; p < 2; p++)
      if (g[p]) begin
        pend[p] = 1'b0;
        req[p]  = 1'b0;
      end
  endtask

  task automatic new_cmd(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[p]   = 1'b1;
    wr[p]    = w;
    addr[p]  = a;
    wdata[p] = d;
    pend[p]  = 1'b1;
  endtask

  logic [AW-1:0] rd_addrs [5];
  logic [DW-1:0] rd_vals [5];
  int            nrd;

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      env_mem[i] = '0;
      ref_mem[i] = '0;
    end
    mem_rd_data = '0;
    rst = 1'b1;
    req = 2'b00;
    wr  = 2'b00;
    for (int p = 0; p < 2; p++) begin
      addr[p]  = '0;
      wdata[p] = '0;
    end
    @(negedge clk);
    cycle();
    cycle();
    chk("reset_busy", busy, 0);
    chk("reset_mem_en", mem_en, 0);
    rst = 1'b0;

    // Both ports requesting continuously from reset: alternate grants starting with p0.
    gq.delete();
    for (int c = 0; c < 10; c++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p]) new_cmd(p, 1'b1, AW'($urandom_range(16, 31)), DW'($urandom));
      cycle();
    end
    req = 2'b00;
    pend = 2'b00;
    repeat (4) cycle();
    chk("rr_grant_count", gq.size() >= 4, 1);
    for (int i = 0; i < 4 && i < gq.size(); i++) chk("rr_order", gq[i], i % 2);

    // p0 write 0x05 <- 0xA5, then p1 reads it back.
    new_cmd(0, 1'b1, 8'h05, 8'hA5);
    cycle();
    chk("wr_p0_gnt", p0_gnt, 1);
    chk("wr_mem_addr", mem_addr, 8'h05);
    chk("wr_mem_data", mem_wr_data, 8'hA5);
    cycle();
    chk("wr_busy_after", busy, 0);
    new_cmd(1, 1'b0, 8'h05, 8'h00);
    cycle();
    chk("rd_mem_en", mem_en, 1);
    chk("rd_mem_dir", mem_wr_rd, 0);
    cycle();
    cycle();
    chk("rd_p1_valid", p1_rd_valid, 1);
    chk("rd_p1_data", p1_rd_data, 8'hA5);
    chk("rd_p0_quiet", p0_rd_valid, 0);

    // Reset landing in RDWAIT after a p0 grant: read aborted, next tie goes to p0.
    new_cmd(0, 1'b0, 8'h05, 8'h00);
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    chk("rst_rdwait_no_valid", p0_rd_valid, 0);
    chk("rst_rdwait_rd_data", p0_rd_data, 0);
    rst = 1'b0;
    pend = 2'b00;
    new_cmd(0, 1'b1, 8'h20, 8'h11);
    new_cmd(1, 1'b1, 8'h21, 8'h22);
    cycle();
    chk("rst_tie_p0", p0_gnt, 1);
    for (int c = 0; c < 6 && pend[1]; c++) cycle();
    cycle();

    // p0 fills five distinct addresses, then reads them back-to-back.
    for (int k = 0; k < 5; k++) begin
      rd_addrs[k] = AW'(8'h40 + k * 8 + $urandom_range(0, 7));
      rd_vals[k]  = DW'($urandom);
      new_cmd(0, 1'b1, rd_addrs[k], rd_vals[k]);
      for (int c = 0; c < 6 && pend[0]; c++) cycle();
      cycle();
    end
    rv0q.delete();
    nrd = 0;
    for (int c = 0; c < 30; c++) begin
      if (!pend[0] && nrd < 5) begin
        new_cmd(0, 1'b0, rd_addrs[nrd], 8'h00);
        nrd++;
      end
      cycle();
      if (p0_rd_valid) chk("b2b_rd_data", p0_rd_data, rd_vals[rv0q.size() - 1]);
    end
    chk("b2b_pulse_count", rv0q.size(), 5);
    for (int i = 1; i < rv0q.size(); i++) chk("b2b_spacing", rv0q[i] - rv0q[i-1], 3);

    // Random mixed traffic on both ports, small address range for read-after-write hits.
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p]) begin
          if ($urandom_range(0, 2) != 0)
            new_cmd(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
          else
            req[p] = 1'b0;
        end
      cycle();
    end
    req = 2'b00;
    repeat (4) cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: ports clk and rst; rst is sampled only on the rising edge of clk.
REQ-002 Parameter ADDR_WIDTH, default `ADDR_WIDTH, memory address width.
REQ-003 Parameter DATA_WIDTH, default `DATA_WIDTH, memory data width.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 pN_req  input  1  (N=0,1) requester N command pending.
REQ-007 pN_wr_rd  input  1  (N=0,1) 1 = write, 0 = read.
REQ-008 pN_addr  input  ADDR_WIDTH  (N=0,1) command address.
REQ-009 pN_wr_data  input  DATA_WIDTH  (N=0,1) write data.
REQ-010 pN_gnt  output  1  (N=0,1) one-cycle grant pulse.
REQ-011 pN_rd_valid  output  1  (N=0,1) one-cycle read-return pulse.
REQ-012 pN_rd_data  output  DATA_WIDTH  (N=0,1) read data, held until the next read return to port N.
REQ-013 mem_en  output  1  memory enable.
REQ-014 mem_wr_rd  output  1  memory direction, 1 = write.
REQ-015 mem_addr  output  ADDR_WIDTH  memory address.
REQ-016 mem_wr_data  output  DATA_WIDTH  memory write data.
REQ-017 mem_rd_data  input  DATA_WIDTH  memory read data, valid the cycle after an en=1, wr_rd=0 edge.
REQ-018 busy  output  1  high whenever the state is not IDLE.

Function
REQ-019 FSM states: IDLE, ISSUE, RDWAIT.
REQ-020 IDLE: if any pN_req = 1, select a winner, capture its wr_rd, addr and wr_data, and go to ISSUE; otherwise stay in IDLE.
REQ-021 Arbitration: a single requester wins; if both request, the port not granted last wins (round-robin); the last-grant pointer resets to port 1, so port 0 wins the first tie.
REQ-022 ISSUE lasts one cycle: mem_en = 1; mem_wr_rd, mem_addr and mem_wr_data carry the captured command; the winner's pN_gnt = 1; the last-grant pointer updates to the winner.
REQ-023 ISSUE transitions: to IDLE for a write, to RDWAIT for a read.
REQ-024 RDWAIT lasts one cycle: mem_en = 0; at the end of the cycle, capture mem_rd_data into the winner's pN_rd_data; go to IDLE.
REQ-025 The pN_rd_valid of the read winner SHALL pulse in the cycle after RDWAIT, concurrent with IDLE arbitration.
REQ-026 Latency, request seen in IDLE at cycle T: grant and mem_en at T+1; read data valid at T+3.
REQ-027 Throughput: one write per 2 cycles, one read per 3 cycles.
REQ-028 Handshake: a requester holds pN_req and its fields stable until it sees pN_gnt, then may drop pN_req or present a new command in the next cycle.
REQ-029 The arbiter samples requests only in IDLE; the captured command completes even if pN_req falls before grant.
REQ-030 Outside ISSUE, mem_en = 0; mem_wr_rd, mem_addr and mem_wr_data hold their last values.
REQ-031 No more than one pN_gnt and no more than one pN_rd_valid SHALL be high in any cycle.

Reset
REQ-032 While rst = 1 at an edge: state <= IDLE, pointer <= port 1, and all outputs <= 0, including pN_rd_data and mem_* outputs.
REQ-033 Reset mid-operation (ISSUE or RDWAIT) SHALL abort the command: no grant, no rd_valid and mem_en = 0 in the following cycle.

Verification
REQ-034 rst = 1 for 2 cycles -> every output 0, busy = 0.
REQ-035 p0 write, addr 0x05, data 0xA5, cycle T -> at T+1: p0_gnt = 1, mem_en = 1, mem_wr_rd = 1, mem_addr = 0x05, mem_wr_data = 0xA5; at T+2: busy = 0.
REQ-036 Then p1 read of 0x05 at cycle T -> mem_en = 1, mem_wr_rd = 0 at T+1; p1_rd_valid = 1 and p1_rd_data = 0xA5 at T+3; p0_rd_valid stays 0.
REQ-037 Both requests held continuously from reset -> grant order p0, p1, p0, p1; never two grants in one cycle.
REQ-038 rst asserted during RDWAIT -> no rd_valid pulse, all outputs 0, next tie goes to p0.
REQ-039 p0 issues 5 back-to-back reads to 5 random addresses with p1 idle -> 5 p0_rd_valid pulses, 3 cycles apart, data matching prior writes.
